descrambler_frame_sync: RTL and testbench

- Frame synchroniser and sequencer for the additive descrambler in the receive bit path.
- Hunts the raw serial stream for a sync word, confirms it over consecutive frames, then reseeds and gates a 10-bit LFSR descrambler over each payload.
- Flywheels through occasional sync misses; drops lock after repeated misses.
- Sits between the bit-serial line interface and the deframer.

---
 rtl/descrambler_frame_sync.sv | 150 +++++++++++++++
 tb/tb_descrambler_frame_sync.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_frame_sync.sv
// Frame sync hunter/confirmer gating a reseeded 10-bit additive descrambler; bit_in -> bit_out latency 1.
// No backpressure: bit_valid=0 freezes all state and suppresses output pulses.
module descrambler_frame_sync #(
   parameter int                  SYNC_LEN    = 16,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hEB90,
   parameter int                  PAYLOAD_LEN = 256,
   parameter int                  CONFIRM     = 2,
   parameter int                  MISS_MAX    = 3,
   parameter logic [9:0]          SEED        = 10'b00_1001_0110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_out,
   output logic       bit_out_valid,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_lost,
   output logic [1:0] state
);

   localparam int FRAME_LEN = PAYLOAD_LEN + SYNC_LEN;
   localparam int POS_W     = $clog2(FRAME_LEN);
   localparam int HIT_W     = $clog2(CONFIRM) + 1;
   localparam int MISS_W    = $clog2(MISS_MAX) + 1;

   localparam logic [POS_W-1:0]  LAST_POS = POS_W'(FRAME_LEN - 1);
   localparam logic [POS_W-1:0]  PAY_END  = POS_W'(PAYLOAD_LEN);
   localparam logic [HIT_W-1:0]  HIT_LOCK = HIT_W'(CONFIRM);
   localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

   typedef enum logic [1:0] {
      HUNT  = 2'b00,
      CHECK = 2'b01,
      LOCK  = 2'b10
   } state_t;

   state_t              st;
   // Only the newest SYNC_LEN-1 bits can still contribute to a future match.
   logic [SYNC_LEN-2:0] hist;
   logic [POS_W-1:0]    pos;
   logic [9:0]          q;
   logic [HIT_W-1:0]    hits;
   logic [MISS_W-1:0]   misses;

   logic                match;
   logic                fb;
   logic                in_payload;
   logic                at_boundary;
   logic [HIT_W-1:0]    hits_nxt;
   logic [MISS_W-1:0]   misses_nxt;
   logic [POS_W-1:0]    pos_nxt;

   assign match       = ({hist, bit_in} == SYNC_WORD);
   assign fb          = q[8] ^ q[2] ^ q[0];
   assign in_payload  = (pos < PAY_END);
   assign at_boundary = (pos == LAST_POS);
   assign hits_nxt    = hits + HIT_W'(1);
   assign misses_nxt  = misses + MISS_W'(1);
   assign pos_nxt     = pos + POS_W'(1);
   assign state       = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st            <= HUNT;
         hist          <= '0;
         pos           <= '0;
         q             <= SEED;
         hits          <= '0;
         misses        <= '0;
         bit_out       <= 1'b0;
         bit_out_valid <= 1'b0;
         frame_start   <= 1'b0;
         locked        <= 1'b0;
         sync_lost     <= 1'b0;
      end else begin
         bit_out_valid <= 1'b0;
         frame_start   <= 1'b0;
         sync_lost     <= 1'b0;
         if (bit_valid) begin
            hist <= {hist[SYNC_LEN-3:0], bit_in};
            case (st)
               HUNT: begin
                  if (match) begin
                     pos    <= '0;
                     q      <= SEED;
                     hits   <= HIT_W'(1);
                     misses <= '0;
                     if (CONFIRM == 1) begin
                        st     <= LOCK;
                        locked <= 1'b1;
                     end else begin
                        st <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  if (in_payload) begin
                     q   <= {fb, q[9:1]};
                     pos <= pos_nxt;
                  end else if (!at_boundary) begin
                     pos <= pos_nxt;
                  end else if (match) begin
                     hits <= hits_nxt;
                     q    <= SEED;
                     pos  <= '0;
                     if (hits_nxt == HIT_LOCK) begin
                        st     <= LOCK;
                        locked <= 1'b1;
                        misses <= '0;
                     end
                  end else begin
                     st  <= HUNT;
                     pos <= '0;
                  end
               end
               LOCK: begin
                  if (in_payload) begin
                     bit_out       <= bit_in ^ fb;
                     bit_out_valid <= 1'b1;
                     frame_start   <= (pos == '0);
                     q             <= {fb, q[9:1]};
                     pos           <= pos_nxt;
                  end else if (!at_boundary) begin
                     pos <= pos_nxt;
                  end else if (match) begin
                     misses <= '0;
                     q      <= SEED;
                     pos    <= '0;
                  end else if (misses_nxt < MISS_LIM) begin
                     // Flywheel: assume the sync was corrupted, keep frame timing.
                     misses <= misses_nxt;
                     q      <= SEED;
                     pos    <= '0;
                  end else begin
                     st        <= HUNT;
                     locked    <= 1'b0;
                     sync_lost <= 1'b1;
                     misses    <= '0;
                     pos       <= '0;
                  end
               end
               default: st <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_descrambler_frame_sync.sv
// Randomised bench for descrambler_frame_sync against a frame-level reference model.
module tb_descrambler_frame_sync;

   localparam int          PAY      = 256;
   localparam int          CONFIRM  = 2;
   localparam int          MISS_MAX = 3;
   localparam logic [15:0] SYNC     = 16'hEB90;
   localparam logic [15:0] BAD      = 16'hEB91;
   localparam logic [9:0]  SEED     = 10'b00_1001_0110;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_in;
   logic       bit_valid;
   logic       bit_out;
   logic       bit_out_valid;
   logic       frame_start;
   logic       locked;
   logic       sync_lost;
   logic [1:0] state;

   always #5 clk = ~clk;

   descrambler_frame_sync #(
      .SYNC_LEN(16), .SYNC_WORD(SYNC), .PAYLOAD_LEN(PAY),
      .CONFIRM(CONFIRM), .MISS_MAX(MISS_MAX), .SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_out(bit_out), .bit_out_valid(bit_out_valid), .frame_start(frame_start),
      .locked(locked), .sync_lost(sync_lost), .state(state)
   );

   typedef struct {
      logic           good;
      logic [PAY-1:0] pay;
   } frame_t;

   frame_t frames[$];
   logic   ks[PAY];
   logic   got_bits[$];
   logic   got_fs[$];
   logic   exp_bits[$];
   logic   exp_fs[$];
   int     exp_lost;
   int     lost_cnt  = 0;
   int     stray_cnt = 0;
   int     tests_run = 0;
   int     fails     = 0;
   logic   valid_d;

   // Output monitor
   always @(posedge clk) valid_d <= bit_valid;

   always @(negedge clk) begin
      if (bit_out_valid === 1'b1) begin
         got_bits.push_back(bit_out);
         got_fs.push_back(frame_start);
         if (valid_d !== 1'b1) stray_cnt++;
      end
      if (frame_start === 1'b1 && bit_out_valid !== 1'b1) stray_cnt++;
      if (sync_lost === 1'b1) lost_cnt++;
   end

   // Keystream as the linear recurrence x[m+10] = x[m+8]^x[m+2]^x[m], seeded by SEED bits.
   function automatic void gen_ks();
      logic       x[PAY+10];
      logic [9:0] s = SEED;
      for (int i = 0; i < 10; i++) x[i] = s[i];
      for (int m = 0; m < PAY; m++) x[m+10] = x[m+8] ^ x[m+2] ^ x[m];
      for (int n = 0; n < PAY; n++) ks[n] = x[n+10];
   endfunction

   // Frame-granular lock model: which payloads are emitted, how many losses occur.
   function automatic void build_expected();
      int mode   = 0;
      int hits   = 0;
      int misses = 0;
      exp_bits.delete();
      exp_fs.delete();
      exp_lost = 0;
      foreach (frames[f]) begin
         if (mode == 0) begin
            if (frames[f].good) begin
               hits   = 1;
               misses = 0;
               mode   = (CONFIRM == 1) ? 2 : 1;
            end
         end else if (mode == 1) begin
            if (frames[f].good) begin
               hits++;
               if (hits >= CONFIRM) begin
                  mode   = 2;
                  misses = 0;
               end
            end else begin
               mode = 0;
            end
         end else begin
            if (frames[f].good) misses = 0;
            else begin
               misses++;
               if (misses >= MISS_MAX) begin
                  mode = 0;
                  exp_lost++;
               end
            end
         end
         if (mode == 2) begin
            for (int i = 0; i < PAY; i++) begin
               exp_bits.push_back(frames[f].pay[i] ^ ks[i]);
               exp_fs.push_back(i == 0);
            end
         end
      end
   endfunction

   function automatic int first_diff(input int base);
      for (int i = 0; i < exp_bits.size(); i++) begin
         if (base + i >= got_bits.size()) return i;
         if (got_bits[base+i] !== exp_bits[i] || got_fs[base+i] !== exp_fs[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [PAY-1:0] rand_pay();
      logic [PAY-1:0] p;
      for (int k = 0; k < PAY / 32; k++) p[k*32 +: 32] = $urandom;
      return p;
   endfunction

   function automatic void add_frame(input logic good, input logic [PAY-1:0] p);
      frame_t fr;
      fr.good = good;
      fr.pay  = p;
      frames.push_back(fr);
   endfunction

   task automatic send_bit(input logic b, input int gap);
      bit_in    = b;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int pick_gap(input int gap_mode);
      if (gap_mode == 1) return 1;
      if (gap_mode == 2) return int'($urandom_range(0, 2));
      return 0;
   endfunction

   task automatic send_sync(input logic [15:0] w, input int gap_mode);
      for (int i = 15; i >= 0; i--) send_bit(w[i], pick_gap(gap_mode));
   endtask

   task automatic send_pay(input logic [PAY-1:0] p, input int gap_mode);
      for (int i = 0; i < PAY; i++) send_bit(p[i], pick_gap(gap_mode));
   endtask

   task automatic run_frames(input int gap_mode);
      foreach (frames[f]) begin
         send_sync(frames[f].good ? SYNC : BAD, gap_mode);
         send_pay(frames[f].pay, gap_mode);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      frames.delete();
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      rst       = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      obs = {state, locked, sync_lost, bit_out_valid, frame_start, bit_out};
      tests_run++;
      if (obs !== 7'b0) begin
         fails++;
         $display("FAIL reset_hold: outputs %b, expected 0000000", obs);
      end
      bit_valid = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      obs = {state, locked, sync_lost, bit_out_valid, frame_start, bit_out};
      tests_run++;
      if (obs !== 7'b0) begin
         fails++;
         $display("FAIL reset_release: outputs %b, expected 0000000", obs);
      end
   endtask

   task automatic test_acquire();
      int         base;
      logic [4:0] first5;
      do_reset();
      base = got_bits.size();
      send_sync(SYNC, 0);
      send_pay('0, 0);
      tests_run++;
      if (got_bits.size() != base || state !== 2'b01) begin
         fails++;
         $display("FAIL acquire_check: outputs %0d state %b, expected 0 and 01", got_bits.size() - base, state);
      end
      send_sync(SYNC, 0);
      tests_run++;
      if (locked !== 1'b1 || state !== 2'b10) begin
         fails++;
         $display("FAIL acquire_lock: locked %b state %b, expected 1 and 10", locked, state);
      end
      send_pay('0, 0);
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (got_bits.size() - base != PAY) begin
         fails++;
         $display("FAIL acquire_count: %0d bits, expected %0d", got_bits.size() - base, PAY);
      end else begin
         first5 = {got_bits[base], got_bits[base+1], got_bits[base+2], got_bits[base+3], got_bits[base+4]};
         tests_run++;
         if (first5 !== 5'b11110 || got_fs[base] !== 1'b1) begin
            fails++;
            $display("FAIL acquire_first: bits %b fs %b, expected 11110 and 1", first5, got_fs[base]);
         end
      end
      add_frame(1'b1, '0);
      add_frame(1'b1, '0);
      build_expected();
      tests_run++;
      if (first_diff(base) != -1) begin
         fails++;
         $display("FAIL acquire_stream: first difference at bit %0d", first_diff(base));
      end
   endtask

   task automatic test_flywheel();
      int         base;
      int         lost0;
      logic [4:0] first5;
      do_reset();
      base  = got_bits.size();
      lost0 = lost_cnt;
      add_frame(1'b1, rand_pay());
      add_frame(1'b1, rand_pay());
      add_frame(1'b0, '0);
      add_frame(1'b1, rand_pay());
      run_frames(0);
      build_expected();
      tests_run++;
      if (got_bits.size() - base != exp_bits.size() || first_diff(base) != -1) begin
         fails++;
         $display("FAIL flywheel_stream: %0d bits (first diff %0d), expected %0d bits",
                  got_bits.size() - base, first_diff(base), exp_bits.size());
      end
      tests_run++;
      if (lost_cnt != lost0 || locked !== 1'b1) begin
         fails++;
         $display("FAIL flywheel_lock: lost %0d locked %b, expected 0 and 1", lost_cnt - lost0, locked);
      end
      if (got_bits.size() >= base + 2 * PAY) begin
         first5 = {got_bits[base+PAY], got_bits[base+PAY+1], got_bits[base+PAY+2],
                   got_bits[base+PAY+3], got_bits[base+PAY+4]};
         tests_run++;
         if (first5 !== 5'b11110) begin
            fails++;
            $display("FAIL flywheel_reseed: bits %b, expected 11110", first5);
         end
      end
   endtask

   task automatic test_loss();
      int base;
      int lost0;
      do_reset();
      base  = got_bits.size();
      lost0 = lost_cnt;
      add_frame(1'b1, rand_pay());
      add_frame(1'b1, rand_pay());
      add_frame(1'b0, rand_pay());
      add_frame(1'b0, rand_pay());
      run_frames(0);
      send_sync(BAD, 0);
      tests_run++;
      if (sync_lost !== 1'b1 || locked !== 1'b0 || state !== 2'b00) begin
         fails++;
         $display("FAIL loss_pulse: sync_lost %b locked %b state %b, expected 1 0 00", sync_lost, locked, state);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (sync_lost !== 1'b0) begin
         fails++;
         $display("FAIL loss_one_cycle: sync_lost %b, expected 0", sync_lost);
      end
      send_pay('0, 0);
      repeat (3) @(posedge clk);
      #1;
      add_frame(1'b0, '0);
      build_expected();
      tests_run++;
      if (got_bits.size() - base != exp_bits.size() || first_diff(base) != -1 || lost_cnt - lost0 != exp_lost) begin
         fails++;
         $display("FAIL loss_stream: %0d bits lost %0d, expected %0d bits lost %0d",
                  got_bits.size() - base, lost_cnt - lost0, exp_bits.size(), exp_lost);
      end
   endtask

   task automatic test_embedded();
      int             base;
      int             lost0;
      int             off;
      logic [PAY-1:0] p;
      logic [15:0]    w = SYNC;
      do_reset();
      base  = got_bits.size();
      lost0 = lost_cnt;
      p     = rand_pay();
      off   = int'($urandom_range(0, PAY - 16));
      for (int j = 0; j < 16; j++) p[off+j] = w[15-j];
      add_frame(1'b1, rand_pay());
      add_frame(1'b1, rand_pay());
      add_frame(1'b1, p);
      add_frame(1'b1, rand_pay());
      run_frames(0);
      build_expected();
      tests_run++;
      if (got_bits.size() - base != exp_bits.size() || first_diff(base) != -1) begin
         fails++;
         $display("FAIL embedded_stream: %0d bits (first diff %0d), expected %0d bits, sync at %0d",
                  got_bits.size() - base, first_diff(base), exp_bits.size(), off);
      end
      tests_run++;
      if (lost_cnt != lost0 || locked !== 1'b1) begin
         fails++;
         $display("FAIL embedded_lock: lost %0d locked %b, expected 0 and 1", lost_cnt - lost0, locked);
      end
   endtask

   task automatic test_gapped();
      int base;
      int stray0;
      for (int mode = 1; mode <= 2; mode++) begin
         do_reset();
         base   = got_bits.size();
         stray0 = stray_cnt;
         add_frame(1'b1, rand_pay());
         add_frame(1'b1, rand_pay());
         add_frame(1'b1, rand_pay());
         run_frames(mode);
         build_expected();
         tests_run++;
         if (got_bits.size() - base != exp_bits.size() || first_diff(base) != -1) begin
            fails++;
            $display("FAIL gapped_stream_%0d: %0d bits (first diff %0d), expected %0d bits",
                     mode, got_bits.size() - base, first_diff(base), exp_bits.size());
         end
         tests_run++;
         if (stray_cnt != stray0) begin
            fails++;
            $display("FAIL gapped_valid_%0d: %0d stray output cycles, expected 0", mode, stray_cnt - stray0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int         base;
      logic [6:0] obs;
      logic [4:0] first5;
      do_reset();
      send_sync(SYNC, 0);
      send_pay(rand_pay(), 0);
      send_sync(SYNC, 0);
      for (int i = 0; i < 100; i++) send_bit(1'($urandom), 0);
      bit_valid = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      obs = {state, locked, sync_lost, bit_out_valid, frame_start, bit_out};
      tests_run++;
      if (obs !== 7'b0) begin
         fails++;
         $display("FAIL reset_mid: outputs %b, expected 0000000", obs);
      end
      bit_valid = 1'b0;
      @(posedge clk);
      #1;
      rst  = 1'b1;
      base = got_bits.size();
      send_sync(SYNC, 0);
      send_pay('0, 0);
      tests_run++;
      if (locked !== 1'b0 || state !== 2'b01) begin
         fails++;
         $display("FAIL reset_relock_one: locked %b state %b, expected 0 and 01", locked, state);
      end
      send_sync(SYNC, 0);
      send_pay('0, 0);
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (got_bits.size() - base != PAY || locked !== 1'b1) begin
         fails++;
         $display("FAIL reset_relock_two: %0d bits locked %b, expected %0d and 1", got_bits.size() - base, locked, PAY);
      end else begin
         first5 = {got_bits[base], got_bits[base+1], got_bits[base+2], got_bits[base+3], got_bits[base+4]};
         tests_run++;
         if (first5 !== 5'b11110) begin
            fails++;
            $display("FAIL reset_relock_bits: bits %b, expected 11110", first5);
         end
      end
   endtask

   initial begin
      rst       = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      gen_ks();
      test_reset();
      test_acquire();
      test_flywheel();
      test_loss();
      test_embedded();
      test_gapped();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
